argmax_result_collector: RTL
============================

Name: argmax_result_collector

Overview:
Downstream consumer of the argmax cell chain. It captures each completed argmax result from the last cell's output_result bus, where bit RESULT_WIDTH is the valid flag and bits RESULT_WIDTH-1:0 are the payload. Results are buffered in a first-word-fall-through FIFO and presented to the host/DMA side on a valid/ready stream. It also counts accepted results and flags dropped ones.

Parameters:
RESULT_WIDTH, 16, payload width of an argmax result (matches the cell's RESULT_WIDTH, i.e. 2*DATA_WIDTH).
FIFO_DEPTH, 8, buffer entries; power of two, >=2.
COUNT_WIDTH, 16, width of the accepted-result counter.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  synchronous, active-high reset.
input_result  input  RESULT_WIDTH+1  from last argmax cell; [RESULT_WIDTH] = valid, [RESULT_WIDTH-1:0] = payload.
output_data  output  RESULT_WIDTH  FIFO head payload; 0 when output_valid=0.
output_valid  output  1  FIFO non-empty.
output_ready  input  1  consumer accepts head this cycle.
fifo_full  output  1  occupancy == FIFO_DEPTH.
overflow  output  1  sticky; a valid input was dropped.
result_count  output  COUNT_WIDTH  number of accepted results, wraps modulo 2^COUNT_WIDTH.

Behaviour:
- Reset (reset=1 at a clk edge): rd/wr pointers=0, occupancy=0, output_valid=0, output_data=0, fifo_full=0, overflow=0, result_count=0. Reset overrides any push/pop in that cycle. Reset mid-stream discards all buffered entries.
- push_req = input_result[RESULT_WIDTH]. pop = output_valid & output_ready. Both are sampled at the rising edge.
- Push accepted iff push_req & (!fifo_full | pop). When full with a simultaneous pop, both occur and occupancy stays FIFO_DEPTH.
- Push dropped iff push_req & fifo_full & !pop. In that case overflow<=1 (sticky until reset) and result_count is unchanged.
- Payload with valid=0 is ignored entirely, whatever its value.
- Latency: a push accepted at edge N gives output_valid=1 and output_data=payload after edge N when the FIFO was empty before it. No same-cycle bypass: input to output is 1 cycle minimum.
- FWFT: output_data always equals the head entry combinationally from registered state. The head is stable while output_valid & !output_ready.
- Pop when empty cannot occur, because output_valid=0. output_ready is ignored while empty.
- Simultaneous push and pop when empty is impossible (pop needs valid). For 0<occupancy<FIFO_DEPTH, simultaneous push+pop leaves occupancy unchanged and both pointers advance.
- Pointers are log2(FIFO_DEPTH) bits, wrap naturally. Occupancy is a separate log2(FIFO_DEPTH)+1 bit counter.
- fifo_full and output_valid are registered or derived from the registered occupancy (no combinational path from input_result or output_ready).
- result_count += 1 on each accepted push and wraps from 2^COUNT_WIDTH-1 to 0.
- Data ordering is strictly FIFO; no reordering, no duplication.

Test Plan:
1. Reset held 2 cycles, then release with input_result=17'h0_0005 (valid=0) -> output_valid=0, output_data=0, result_count=0, overflow=0.
2. Single push input_result={1'b1,16'd3} for 1 cycle, output_ready=0 -> output_valid=1, output_data=3 one edge later; holds 3 for 5 cycles; raise output_ready -> output_valid=0 next edge; result_count=1.
3. Push payloads 1..8 on consecutive cycles with output_ready=0 -> fifo_full=1 after 8th edge; 9th push (payload 9) -> overflow=1, result_count=8; drain with output_ready=1 -> outputs 1..8 in order, 9 never appears.
4. Full FIFO (payloads 1..8), push payload 9 with output_ready=1 same cycle -> head 1 popped, 9 accepted, fifo_full stays 1, overflow=0, result_count=9; drain yields 2..9.
5. Continuous push of 1..20 with output_ready=1 every cycle -> outputs 1..20 each one cycle after input, occupancy never exceeds 1, pointers wrap twice, no overflow.
6. With 3 entries buffered and overflow=1, assert reset for 1 cycle concurrently with a valid push -> all outputs return to reset values; the pushed payload is not stored.

Source files
------------

// File: rtl/argmax_result_collector_if.sv
`default_nettype none
// ============================================================================
//  Module      : argmax_result_collector_if
//  Description : Result-capture and output-stream signals of the argmax
//                result collector. The master modport is the environment
//                (cell chain + host); the slave modport is the collector.
//  Revision    : 1.0 - initial release
// ============================================================================
interface argmax_result_collector_if #(
    parameter int RESULT_WIDTH = 16,
    parameter int COUNT_WIDTH  = 16
);
    logic [RESULT_WIDTH:0]   input_result;
    logic [RESULT_WIDTH-1:0] output_data;
    logic                    output_valid;
    logic                    output_ready;
    logic                    fifo_full;
    logic                    overflow;
    logic [COUNT_WIDTH-1:0]  result_count;

    modport master (
        output input_result,
        output output_ready,
        input  output_data,
        input  output_valid,
        input  fifo_full,
        input  overflow,
        input  result_count
    );

    modport slave (
        input  input_result,
        input  output_ready,
        output output_data,
        output output_valid,
        output fifo_full,
        output overflow,
        output result_count
    );
endinterface
`default_nettype wire

// File: rtl/argmax_result_collector.sv
`default_nettype none
// ============================================================================
//  Module      : argmax_result_collector
//  Description : Captures valid argmax results from the last cell, buffers
//                them in a first-word-fall-through FIFO, streams them out on
//                valid/ready, counts accepted results and flags drops.
//  Revision    : 1.0 - initial release
// ============================================================================
module argmax_result_collector #(
    parameter int RESULT_WIDTH = 16,
    parameter int FIFO_DEPTH   = 8,
    parameter int COUNT_WIDTH  = 16
) (
    input  wire logic               clk,
    input  wire logic               reset,
    argmax_result_collector_if.slave bus
);
    localparam int              c_ptr_w      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [c_ptr_w:0] c_fifo_depth = (c_ptr_w + 1)'(FIFO_DEPTH);

    logic [RESULT_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [RESULT_WIDTH-1:0] mem_d [FIFO_DEPTH];
    logic [c_ptr_w-1:0]      rd_ptr_q, rd_ptr_d;
    logic [c_ptr_w-1:0]      wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w:0]        count_q, count_d;
    logic                    overflow_q, overflow_d;
    logic [COUNT_WIDTH-1:0]  result_count_q, result_count_d;

    logic w_push_req;
    logic w_valid;
    logic w_full;
    logic w_pop;
    logic w_push_acc;
    logic w_drop;

    // Handshake qualifiers; status flags come only from registered occupancy
    always_comb begin
        w_push_req = bus.input_result[RESULT_WIDTH];
        w_valid    = (count_q != '0);
        w_full     = (count_q == c_fifo_depth);
        w_pop      = w_valid & bus.output_ready;
        w_push_acc = w_push_req & (~w_full | w_pop);
        w_drop     = w_push_req & w_full & ~w_pop;
    end

    // Next-state computation for storage, pointers, occupancy and statistics
    always_comb begin
        mem_d          = mem_q;
        rd_ptr_d       = rd_ptr_q;
        wr_ptr_d       = wr_ptr_q;
        count_d        = count_q;
        overflow_d     = overflow_q | w_drop;
        result_count_d = result_count_q;

        if (w_push_acc) begin
            mem_d[wr_ptr_q] = bus.input_result[RESULT_WIDTH-1:0];
            wr_ptr_d        = wr_ptr_q + 1'b1;
            result_count_d  = result_count_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        // Push with pop (including when full) leaves occupancy unchanged
        case ({w_push_acc, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // State register; reset discards buffered entries and overrides push/pop
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q          <= '{default: '0};
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            count_q        <= '0;
            overflow_q     <= 1'b0;
            result_count_q <= '0;
        end else begin
            mem_q          <= mem_d;
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            count_q        <= count_d;
            overflow_q     <= overflow_d;
            result_count_q <= result_count_d;
        end
    end

    // FWFT output: head entry shown directly, forced to zero while empty
    always_comb begin
        bus.output_valid = w_valid;
        bus.output_data  = w_valid ? mem_q[rd_ptr_q] : '0;
        bus.fifo_full    = w_full;
        bus.overflow     = overflow_q;
        bus.result_count = result_count_q;
    end
endmodule
`default_nettype wire
